fir_seq_ctrl: RTL and testbench

Sequencer between the drop-out sample FIFO and the FIR multiply-accumulate datapath in ahb_fir.
- Pops one sample whenever the FIFO is non-empty and the engine is idle.
- Loads the sample into the delay line, then steps the tap index over NTAPS MAC cycles.
- Presents the accumulated result on a valid/ready output handshake.
- Owns all FIFO read_en, delay-line shift and MAC control strobes; holds no arithmetic itself.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_tap_cnt.sv | 42 ++++
 rtl/fir_seq_ctrl.sv | 98 +++++++++
 tb/tb_fir_seq_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR sequencer: FSM state encoding,
// parameter defaults and the tap-index width helper.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        MAC  = 2'd2,
        DONE = 2'd3
    } fir_state_t;

    localparam int DWIDTH_DEF = 8;
    localparam int NTAPS_DEF  = 4;

    // Width of an index that addresses 0..ntaps-1; never narrower than one bit.
    function automatic int fir_tap_w(input int ntaps);
        return (ntaps < 2) ? 1 : $clog2(ntaps);
    endfunction

endpackage

// File: rtl/fir_tap_cnt.sv
// Wrapping tap-index counter: clear, count enable and a terminal-count flag
// that is high while the index sits on the last tap.
module fir_tap_cnt
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int TAP_W = fir_tap_w(NTAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [TAP_W-1:0] cnt,
    output logic             tc
);

    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NTAPS - 1);

    logic [TAP_W-1:0] cnt_reg;
    logic [TAP_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = (cnt_reg == TAP_LAST) ? '0 : cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;
    assign tc  = (cnt_reg == TAP_LAST);

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIFO-to-MAC sequencer for ahb_fir: pop, shift into delay line, NTAPS MAC
// steps, then a valid/ready result. Optional result counter: FIR_SEQ_STAT_EN.
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int NTAPS  = NTAPS_DEF,
    parameter int TAP_W  = fir_tap_w(NTAPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty_flg,
    input  logic [DWIDTH-1:0] fifo_rdata,
    output logic              fifo_read_en,
    output logic [DWIDTH-1:0] smp_data,
    output logic              dl_shift,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [TAP_W-1:0]  tap_idx,
    output logic              res_valid,
    input  logic              res_ready,
`ifdef FIR_SEQ_STAT_EN
    output logic [15:0]       smp_cnt,
`endif
    output logic              busy
);

    fir_state_t        state_reg;
    fir_state_t        state_next;
    logic              read_en_reg;
    logic              read_en_next;
    logic [DWIDTH-1:0] smp_data_reg;
    logic              tap_tc;

    fir_tap_cnt #(
        .NTAPS (NTAPS),
        .TAP_W (TAP_W)
    ) u_tap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_reg == POP),
        .en    (state_reg == MAC),
        .cnt   (tap_idx),
        .tc    (tap_tc)
    );

    // The pop strobe is a flop fed by the empty flag, so it fires during the
    // IDLE cycle that follows a non-empty sample; IDLE then moves on to POP.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (read_en_reg) state_next = POP;
            POP:  state_next = MAC;
            MAC:  if (tap_tc) state_next = DONE;
            DONE: if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        read_en_next = (state_next == IDLE) && !fifo_empty_flg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            read_en_reg  <= 1'b0;
            smp_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            read_en_reg <= read_en_next;
            // Popped word is taken on the edge that retires the pop strobe.
            if (read_en_reg) begin
                smp_data_reg <= fifo_rdata;
            end
        end
    end

    assign fifo_read_en = read_en_reg;
    assign smp_data     = smp_data_reg;
    assign dl_shift     = (state_reg == POP);
    assign mac_en       = (state_reg == MAC);
    assign mac_clr      = (state_reg == MAC) && (tap_idx == '0);
    assign res_valid    = (state_reg == DONE);
    assign busy         = (state_reg != IDLE);

`ifdef FIR_SEQ_STAT_EN
    logic [15:0] smp_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt_reg <= '0;
        end else if (res_valid && res_ready && (smp_cnt_reg != 16'hFFFF)) begin
            smp_cnt_reg <= smp_cnt_reg + 16'd1;
        end
    end

    assign smp_cnt = smp_cnt_reg;
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl (NTAPS=4, DWIDTH=8) with a show-ahead FIFO model.
module tb_fir_seq_ctrl;

    localparam int DW = 8;
    localparam int NT = 4;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty_flg;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_read_en;
    logic [DW-1:0] smp_data;
    logic          dl_shift;
    logic          mac_clr;
    logic          mac_en;
    logic [TW-1:0] tap_idx;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic          busy;
`ifdef FIR_SEQ_STAT_EN
    logic [15:0]   smp_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] mem [0:15];
    logic [3:0]    wr_ptr = '0;
    logic [3:0]    rd_ptr = '0;

    assign fifo_empty_flg = (wr_ptr == rd_ptr);
    assign fifo_rdata     = mem[rd_ptr];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_read_en) rd_ptr <= rd_ptr + 4'd1;
    end

    fir_seq_ctrl #(.DWIDTH(DW), .NTAPS(NT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_empty_flg (fifo_empty_flg),
        .fifo_rdata     (fifo_rdata),
        .fifo_read_en   (fifo_read_en),
        .smp_data       (smp_data),
        .dl_shift       (dl_shift),
        .mac_clr        (mac_clr),
        .mac_en         (mac_en),
        .tap_idx        (tap_idx),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
`ifdef FIR_SEQ_STAT_EN
        .smp_cnt        (smp_cnt),
`endif
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    function automatic logic [15:0] all_outs();
        return {fifo_read_en, dl_shift, mac_clr, mac_en, res_valid, busy, tap_idx, smp_data};
    endfunction

    // Advance negedges until fifo_read_en is seen, bounded by max cycles.
    task automatic wait_pop(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (fifo_read_en) begin
                $display("pop at cycle %0d, head %0h", cyc, fifo_rdata);
                return;
            end
        end
        chk("pop_timeout", {31'd0, fifo_read_en}, 32'd1);
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (res_valid) begin
                $display("result valid at cycle %0d, sample %0h", cyc, smp_data);
                return;
            end
        end
        chk("valid_timeout", {31'd0, res_valid}, 32'd1);
    endtask

    initial begin
        int last_pop;
        int extra;

        // Reset with FIFO empty
        repeat (3) @(negedge clk);
        chk("reset_outs", {16'd0, all_outs()}, 32'd0);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (all_outs() != 16'd0) extra++;
        end
        chk("idle_quiet_10cyc", extra, 0);

        // Single sample 8'h05
        push(8'h05);
        wait_pop(5);
        chk("t0_read_en", {31'd0, fifo_read_en}, 32'd1);
        chk("t0_dl_shift", {31'd0, dl_shift}, 32'd0);
        @(negedge clk);
        chk("t1_smp_data", {24'd0, smp_data}, 32'h05);
        chk("t1_shift_rd", {30'd0, dl_shift, fifo_read_en}, 32'b10);
        for (int i = 0; i < NT; i++) begin
            @(negedge clk);
            chk($sformatf("mac%0d_en_clr", i), {30'd0, mac_en, mac_clr}, (i == 0) ? 32'b11 : 32'b10);
            chk($sformatf("mac%0d_tap", i), {30'd0, tap_idx}, i);
        end
        @(negedge clk);
        chk("t6_valid_mac", {30'd0, res_valid, mac_en}, 32'b10);
        chk("t6_tap_wrap", {30'd0, tap_idx}, 32'd0);
        @(negedge clk);
        chk("t7_idle", {30'd0, res_valid, busy}, 32'd0);

        // Six back-to-back samples 0..5
        for (int k = 0; k < 6; k++) push(DW'(k));
        last_pop = 0;
        for (int k = 0; k < 6; k++) begin
            wait_pop(k == 0 ? 5 : 10);
            if (k > 0) chk($sformatf("gap%0d", k), cyc - last_pop, 7);
            last_pop = cyc;
            @(negedge clk);
            chk($sformatf("burst_smp%0d", k), {24'd0, smp_data}, k);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fifo_read_en) extra++;
        end
        chk("burst_no_extra_pop", extra, 0);
        chk("burst_idle", {31'd0, busy}, 32'd0);

        // Back-pressure: hold res_ready low for 20 cycles
        res_ready = 1'b0;
        push(8'hA5);
        wait_pop(5);
        wait_valid(10);
        push(8'h3C);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!res_valid || fifo_read_en || tap_idx != '0) extra++;
        end
        chk("stall_hold", extra, 0);
        res_ready = 1'b1;
        @(negedge clk);
        chk("release_idle_pop", {30'd0, busy, fifo_read_en}, 32'b01);
        @(negedge clk);
        chk("release_smp", {24'd0, smp_data}, 32'h3C);
        wait_valid(10);
        @(negedge clk);

        // Asynchronous reset in the middle of MAC at tap_idx=2
        push(8'h77);
        wait_pop(5);
        repeat (4) @(negedge clk);
        chk("pre_reset_tap2", {30'd0, tap_idx}, 32'd2);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", {16'd0, all_outs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push(8'h11);
        wait_pop(5);
        @(negedge clk);
        chk("after_rst_smp", {24'd0, smp_data}, 32'h11);
        @(negedge clk);
        chk("after_rst_mac", {28'd0, mac_en, mac_clr, tap_idx}, 32'b1100);
        wait_valid(10);

        // Two more results, three accepted since the reset
        push(8'h22);
        push(8'h33);
        wait_pop(10);
        wait_valid(10);
        wait_pop(10);
        wait_valid(10);
        @(negedge clk);
        chk("final_idle", {31'd0, busy}, 32'd0);
`ifdef FIR_SEQ_STAT_EN
        chk("smp_cnt", {16'd0, smp_cnt}, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
